data_mem_stage: RTL and testbench
=================================

Name: data_mem_stage

Overview:
- Memory-access stage controller between the execute/memory pipeline register and the synchronous single-port data RAM.
- Stores: one cycle, no stall. Loads: pipeline held via stall until synchronous RAM read data is captured.
- Provides flush for killed instructions and an out-of-range address check.
- Read data is handed to the memory/writeback register.

Parameters:
- DATA_W, 16, data and address-in width.
- DEPTH, 4096, RAM words; legal addresses 0..DEPTH-1.
- RAM_ADDR_W, 12, RAM address width (= log2 DEPTH).
- RAM_LAT, 1, cycles from the address-sampling edge to ram_q valid; legal 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory-stage slot holds a valid instruction.
- mm  in  1  instruction accesses memory.
- wme  in  1  1 = store, 0 = load (meaningful only when mm=1).
- addr  in  DATA_W  effective address (ALU result).
- wdata  in  DATA_W  store data.
- flush  in  1  kill the current memory-stage instruction.
- ram_addr  out  RAM_ADDR_W  addr[RAM_ADDR_W-1:0].
- ram_wdata  out  DATA_W  wdata.
- ram_wren  out  1  RAM write strobe.
- ram_q  in  DATA_W  RAM read data.
- stall  out  1  hold all upstream pipeline registers.
- rdata  out  DATA_W  captured load data.
- rdata_valid  out  1  rdata holds this instruction's load result.
- addr_err  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, rdata=0, rdata_valid=0, addr_err=0. ram_wren and stall read 0 while rst=1.
- Decode signals:
  - ld = req_valid & mm & ~wme & ~flush
  - st = req_valid & mm & wme & ~flush
  - oob = addr >= DEPTH
- ram_addr and ram_wdata are combinational pass-throughs. Upstream holds addr and wdata stable while stall=1.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - ram_wren = st & ~oob (combinational, exactly one cycle). No stall.
  - st & oob: no write; addr_err=1 next cycle.
  - ld & ~oob: stall=1 (combinational). At the edge, go to WAIT with cnt=1.
  - ld & oob: no stall; rdata<=0, rdata_valid<=1, addr_err<=1 at the edge.
  - Otherwise (mm=0, req_valid=0, flush=1): rdata_valid<=0, no RAM activity.
- WAIT:
  - stall=1, ram_wren=0.
  - cnt<RAM_LAT: cnt increments.
  - cnt==RAM_LAT: rdata<=ram_q, rdata_valid<=1, go to DONE, cnt<=0.
- DONE:
  - stall=0. The pipeline advances at this edge; rdata and rdata_valid are sampled by the writeback register.
  - rdata_valid<=0 at the edge (unless the next IDLE-type event sets it). Go to IDLE.
  - A new request is not evaluated in DONE; it is evaluated in the following IDLE cycle.
- Load timing:
  - stall is high for RAM_LAT+1 consecutive cycles.
  - A load occupies the stage for RAM_LAT+2 cycles.
  - A store or non-memory instruction occupies it for 1 cycle.
- Flush:
  - In IDLE: suppresses ram_wren and load start.
  - In WAIT: abort, go to IDLE, cnt=0, no rdata update, rdata_valid=0, stall drops in the following cycle.
  - In DONE: no effect (data already committed).
- addr_err is a registered one-cycle pulse; it is never set by a flushed request.
- Back-to-back loads: the second load is detected in the IDLE cycle after DONE; no data corruption.
- Reset asserted in WAIT: immediate return to IDLE, the pending read is discarded, stall drops asynchronously.

Test Plan:
- Store addr=0x0010, wdata=0xBEEF, mm=1, wme=1: ram_wren=1 for exactly 1 cycle, ram_addr=0x010, stall never high; a subsequent load of 0x0010 gives rdata=0xBEEF with rdata_valid=1.
- RAM_LAT=1 load with ram_q model returning 0x1234: stall high for 2 cycles; rdata=0x1234 and rdata_valid=1 in the DONE cycle; stall=0 in DONE. Repeat with RAM_LAT=3: stall high for 4 cycles.
- Load of 0x2000 (>= DEPTH): no stall, rdata=0, rdata_valid=1 and addr_err=1 for one cycle. Store of 0xFFFF: ram_wren stays 0, addr_err pulses once.
- Load started, flush=1 in the first WAIT cycle (RAM_LAT=2): FSM returns to IDLE, rdata keeps its previous value, rdata_valid=0, stall low from the next cycle.
- rst asserted mid-WAIT: stall, rdata_valid and ram_wren drop to 0 without waiting for a clock edge; after release, a store to 0x0001 executes normally.
- Two back-to-back loads (0x0004, then 0x0005) followed by a non-memory instruction (mm=0): two rdata_valid pulses with the correct data; no ram_wren; the mm=0 instruction passes with no stall.

Source files
------------

// File: rtl/data_mem_stage.sv
// Memory-access stage: drives the synchronous data RAM; stores and non-memory ops pass in 1 cycle.
// Loads hold the pipeline (stall) for RAM_LAT+1 cycles and occupy the stage for RAM_LAT+2 cycles.
module data_mem_stage #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4096,
    parameter int RAM_ADDR_W = 12,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  mm,
    input  logic                  wme,
    input  logic [DATA_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  flush,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_wren,
    input  logic [DATA_W-1:0]     ram_q,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int                CNT_W   = 2;
    localparam logic [CNT_W-1:0]  LAT_C   = CNT_W'(RAM_LAT);
    localparam logic [DATA_W:0]   DEPTH_X = (DATA_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                aerr_q, aerr_d;

    logic ld;
    logic st;
    logic oob;
    logic wren_c;
    logic stall_c;

    assign ld  = req_valid & mm & ~wme & ~flush;
    assign st  = req_valid & mm & wme & ~flush;
    // Extra top bit keeps the compare correct even when DEPTH spans the full address range.
    assign oob = ({1'b0, addr} >= DEPTH_X);

    assign ram_addr  = addr[RAM_ADDR_W-1:0];
    assign ram_wdata = wdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        aerr_d   = 1'b0;
        wren_c   = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (st) begin
                    wren_c = ~oob;
                    aerr_d = oob;
                end else if (ld) begin
                    if (oob) begin
                        rdata_d  = '0;
                        rvalid_d = 1'b1;
                        aerr_d   = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAT_C) begin
                    rdata_d  = ram_q;
                    rvalid_d = 1'b1;
                    state_d  = DONE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Writeback samples rdata at this edge; the next request is seen in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
        end
    end

    // Gated by rst so the strobes drop the moment reset asserts, even with a load still presented.
    assign ram_wren    = wren_c & ~rst;
    assign stall       = stall_c & ~rst;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign addr_err    = aerr_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: three instances (RAM_LAT 1..3), one driven at a time, checked per cycle
// against a transaction-level timing model plus directed literal expectations.
module tb_data_mem_stage;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;
    localparam int NI    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          mm = 1'b0;
    logic          wme = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    int            sel = 0;

    logic [AW-1:0] ram_addr_w  [NI];
    logic [DW-1:0] ram_wdata_w [NI];
    logic [DW-1:0] ram_q_w     [NI];
    logic [DW-1:0] rdata_w     [NI];
    logic [NI-1:0] wren_w, stall_w, rv_w, err_w;

    logic          stall_s, wren_s, rv_s, err_s;
    logic [DW-1:0] rdata_s, ram_wdata_s;
    logic [AW-1:0] ram_addr_s;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fillw(input int k, input int a);
        return DW'(a * 40503 + k * 7919 + 17);
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int LAT = k + 1;
        logic [DW-1:0] mem  [DEPTH] = '{default: '0};
        logic [DW-1:0] pipe [LAT];

        data_mem_stage #(
            .DATA_W(DW), .DEPTH(DEPTH), .RAM_ADDR_W(AW), .RAM_LAT(LAT)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid && (sel == k)), .mm(mm), .wme(wme),
            .addr(addr), .wdata(wdata), .flush(flush),
            .ram_addr(ram_addr_w[k]), .ram_wdata(ram_wdata_w[k]), .ram_wren(wren_w[k]),
            .ram_q(ram_q_w[k]), .stall(stall_w[k]),
            .rdata(rdata_w[k]), .rdata_valid(rv_w[k]), .addr_err(err_w[k])
        );

        // Synchronous RAM with LAT cycles of read latency; unwritten words read as fillw().
        always @(posedge clk) begin
            pipe[0] <= mem[ram_addr_w[k]] ^ fillw(k, int'(ram_addr_w[k]));
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            if (wren_w[k]) mem[ram_addr_w[k]] <= ram_wdata_w[k] ^ fillw(k, int'(ram_addr_w[k]));
        end
        assign ram_q_w[k] = pipe[LAT-1];
    end

    assign stall_s     = stall_w[sel];
    assign wren_s      = wren_w[sel];
    assign rv_s        = rv_w[sel];
    assign err_s       = err_w[sel];
    assign rdata_s     = rdata_w[sel];
    assign ram_addr_s  = ram_addr_w[sel];
    assign ram_wdata_s = ram_wdata_w[sel];

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt = 0, wren_cnt = 0, rv_cnt = 0, err_cnt = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [NI][DEPTH];
    logic [DW-1:0] m_rd [NI];
    logic          cur_rv, cur_err;
    logic [DW-1:0] cur_rd;
    logic          e_stall, e_wren, e_rv, e_err;
    logic [DW-1:0] e_rd, e_wdata;
    logic [AW-1:0] e_addr;
    logic          chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (inst %0d, t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    function automatic logic is_oob(input logic [DW-1:0] a);
        return int'(a) >= DEPTH;
    endfunction

    // One clock cycle: present inputs, publish expected outputs, advance the registered model.
    task automatic cyc(input logic rv_i, input logic mm_i, input logic wme_i, input logic fl_i,
                       input logic [DW-1:0] a, input logic [DW-1:0] d,
                       input logic x_stall, input logic x_wren,
                       input logic n_rv, input logic [DW-1:0] n_rd, input logic n_err);
        req_valid = rv_i; mm = mm_i; wme = wme_i; flush = fl_i; addr = a; wdata = d;
        e_stall = x_stall; e_wren = x_wren;
        e_rv = cur_rv; e_rd = cur_rd; e_err = cur_err;
        e_addr = a[AW-1:0]; e_wdata = d;
        chk = 1'b1;
        @(posedge clk);
        #1;
        cur_rv = n_rv; cur_rd = n_rd; cur_err = n_err;
        m_rd[sel] = n_rd;
    endtask

    // One instruction. fl_at: -1 none, 0 flush at issue, 1..lat flush in that WAIT cycle, lat+1 in DONE.
    task automatic op(input logic rv_i, input logic mm_i, input logic wme_i,
                      input logic [DW-1:0] a, input logic [DW-1:0] d, input int fl_at);
        int   lat;
        logic f0, ld, st, o;
        lat = sel + 1;
        f0  = (fl_at == 0);
        ld  = rv_i & mm_i & ~wme_i & ~f0;
        st  = rv_i & mm_i & wme_i & ~f0;
        o   = is_oob(a);
        if (st) begin
            cyc(rv_i, mm_i, wme_i, 1'b0, a, d, 1'b0, ~o, 1'b0, cur_rd, o);
            if (!o) ref_mem[sel][a[AW-1:0]] = d;
        end else if (ld && o) begin
            cyc(rv_i, mm_i, wme_i, 1'b0, a, d, 1'b0, 1'b0, 1'b1, '0, 1'b1);
        end else if (ld) begin
            cyc(rv_i, mm_i, wme_i, 1'b0, a, d, 1'b1, 1'b0, 1'b0, cur_rd, 1'b0);
            for (int j = 1; j <= lat; j++) begin
                if (fl_at == j) begin
                    cyc(rv_i, mm_i, wme_i, 1'b1, a, d, 1'b1, 1'b0, 1'b0, cur_rd, 1'b0);
                    return;
                end
                if (j == lat)
                    cyc(rv_i, mm_i, wme_i, 1'b0, a, d, 1'b1, 1'b0, 1'b1, ref_mem[sel][a[AW-1:0]], 1'b0);
                else
                    cyc(rv_i, mm_i, wme_i, 1'b0, a, d, 1'b1, 1'b0, 1'b0, cur_rd, 1'b0);
            end
            cyc(rv_i, mm_i, wme_i, fl_at == lat + 1, a, d, 1'b0, 1'b0, 1'b0, cur_rd, 1'b0);
        end else begin
            cyc(rv_i, mm_i, wme_i, f0, a, d, 1'b0, 1'b0, 1'b0, cur_rd, 1'b0);
        end
    endtask

    task automatic nop();
        op(1'b1, 1'b0, 1'b0, 16'h0123, 16'h0, -1);
    endtask

    task automatic select(input int k);
        sel = k;
        cur_rv = 1'b0; cur_err = 1'b0; cur_rd = m_rd[k];
    endtask

    initial begin
        int s_st, s_wr, s_rv, s_er;
        logic [DW-1:0] keep;

        for (int k = 0; k < NI; k++) begin
            m_rd[k] = '0;
            for (int a = 0; a < DEPTH; a++) ref_mem[k][a] = fillw(k, a);
        end

        fork
            forever begin
                @(negedge clk);
                if (stall_s) stall_cnt++;
                if (wren_s)  wren_cnt++;
                if (rv_s)    rv_cnt++;
                if (err_s)   err_cnt++;
                if (chk) begin
                    check("stall", 32'(stall_s), 32'(e_stall));
                    check("ram_wren", 32'(wren_s), 32'(e_wren));
                    check("rdata_valid", 32'(rv_s), 32'(e_rv));
                    check("rdata", 32'(rdata_s), 32'(e_rd));
                    check("addr_err", 32'(err_s), 32'(e_err));
                    check("ram_addr", 32'(ram_addr_s), 32'(e_addr));
                    check("ram_wdata", 32'(ram_wdata_s), 32'(e_wdata));
                end
            end
        join_none

        // Reset state, with a load and then a store presented to show the strobes stay low.
        #1 rst = 1'b1;
        req_valid = 1'b1; mm = 1'b1; wme = 1'b0; addr = 16'h0005;
        #1;
        check("rst_stall", 32'(stall_s), 32'h0);
        check("rst_rdata", 32'(rdata_s), 32'h0);
        check("rst_rvalid", 32'(rv_s), 32'h0);
        check("rst_err", 32'(err_s), 32'h0);
        wme = 1'b1;
        #1;
        check("rst_wren", 32'(wren_s), 32'h0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cur_rv = 1'b0; cur_err = 1'b0; cur_rd = '0;

        // RAM_LAT = 1
        select(0);
        s_st = stall_cnt; s_wr = wren_cnt;
        op(1, 1, 1, 16'h0010, 16'hBEEF, -1);
        check("st_wren_cycles", 32'(wren_cnt - s_wr), 32'd1);
        check("st_stall_cycles", 32'(stall_cnt - s_st), 32'd0);
        s_st = stall_cnt; s_rv = rv_cnt;
        op(1, 1, 0, 16'h0010, 16'h0, -1);
        check("ld_beef", 32'(rdata_s), 32'hBEEF);
        check("ld_lat1_stall", 32'(stall_cnt - s_st), 32'd2);
        check("ld_lat1_rv", 32'(rv_cnt - s_rv), 32'd1);
        op(1, 1, 1, 16'h0020, 16'h1234, -1);
        op(1, 1, 0, 16'h0020, 16'h0, -1);
        check("ld_1234", 32'(rdata_s), 32'h1234);

        s_st = stall_cnt; s_er = err_cnt; s_rv = rv_cnt;
        op(1, 1, 0, 16'h2000, 16'h0, -1);
        nop();
        check("oob_ld_stall", 32'(stall_cnt - s_st), 32'd0);
        check("oob_ld_err", 32'(err_cnt - s_er), 32'd1);
        check("oob_ld_rv", 32'(rv_cnt - s_rv), 32'd1);
        check("oob_ld_rdata", 32'(rdata_s), 32'h0);
        s_wr = wren_cnt; s_er = err_cnt;
        op(1, 1, 1, 16'hFFFF, 16'h5555, -1);
        nop();
        check("oob_st_wren", 32'(wren_cnt - s_wr), 32'd0);
        check("oob_st_err", 32'(err_cnt - s_er), 32'd1);
        s_er = err_cnt;
        op(1, 1, 1, 16'h3000, 16'h1111, 0);
        nop();
        check("flushed_oob_err", 32'(err_cnt - s_er), 32'd0);
        op(1, 1, 1, 16'h0050, 16'h9999, 0);
        op(1, 1, 0, 16'h0050, 16'h0, -1);

        op(1, 1, 1, 16'h0004, 16'h4444, -1);
        op(1, 1, 1, 16'h0005, 16'h5555, -1);
        s_wr = wren_cnt; s_rv = rv_cnt;
        op(1, 1, 0, 16'h0004, 16'h0, -1);
        check("b2b_first", 32'(rdata_s), 32'h4444);
        op(1, 1, 0, 16'h0005, 16'h0, -1);
        check("b2b_second", 32'(rdata_s), 32'h5555);
        s_st = stall_cnt;
        nop();
        check("b2b_rv_pulses", 32'(rv_cnt - s_rv), 32'd2);
        check("b2b_no_wren", 32'(wren_cnt - s_wr), 32'd0);
        check("b2b_nop_stall", 32'(stall_cnt - s_st), 32'd0);

        // RAM_LAT = 3, including reset in the middle of WAIT
        select(2);
        op(1, 1, 1, 16'h0030, 16'h1234, -1);
        s_st = stall_cnt;
        op(1, 1, 0, 16'h0030, 16'h0, -1);
        check("ld_lat3_stall", 32'(stall_cnt - s_st), 32'd4);
        check("ld_lat3_rdata", 32'(rdata_s), 32'h1234);
        cyc(1, 1, 0, 0, 16'h0030, 16'h0, 1'b1, 1'b0, 1'b0, cur_rd, 1'b0);
        cyc(1, 1, 0, 0, 16'h0030, 16'h0, 1'b1, 1'b0, 1'b0, cur_rd, 1'b0);
        chk = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midwait_rst_stall", 32'(stall_s), 32'h0);
        check("midwait_rst_rvalid", 32'(rv_s), 32'h0);
        check("midwait_rst_wren", 32'(wren_s), 32'h0);
        check("midwait_rst_rdata", 32'(rdata_s), 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < NI; k++) m_rd[k] = '0;
        cur_rv = 1'b0; cur_err = 1'b0; cur_rd = '0;
        s_wr = wren_cnt; s_st = stall_cnt;
        op(1, 1, 1, 16'h0001, 16'h0BAD, -1);
        check("post_rst_wren", 32'(wren_cnt - s_wr), 32'd1);
        check("post_rst_stall", 32'(stall_cnt - s_st), 32'd0);
        op(1, 1, 0, 16'h0001, 16'h0, -1);
        check("post_rst_ld", 32'(rdata_s), 32'h0BAD);

        // RAM_LAT = 2, flush in WAIT and in DONE
        select(1);
        op(1, 1, 1, 16'h0040, 16'h7777, -1);
        op(1, 1, 0, 16'h0040, 16'h0, -1);
        keep = rdata_s;
        check("lat2_ld", 32'(keep), 32'h7777);
        s_st = stall_cnt; s_rv = rv_cnt;
        op(1, 1, 0, 16'h0041, 16'h0, 1);
        nop();
        check("flush_wait_stall", 32'(stall_cnt - s_st), 32'd2);
        check("flush_wait_rv", 32'(rv_cnt - s_rv), 32'd0);
        check("flush_wait_keep", 32'(rdata_s), 32'h7777);
        s_rv = rv_cnt;
        op(1, 1, 0, 16'h0001, 16'h0, 3);
        check("flush_done_rv", 32'(rv_cnt - s_rv), 32'd1);

        // Randomized traffic on every latency
        for (int k = 0; k < NI; k++) begin
            select(k);
            for (int n = 0; n < 150; n++) begin
                logic          r_rv, r_mm, r_wme;
                logic [DW-1:0] r_a;
                int            r_fl;
                r_rv  = ($urandom_range(0, 7) != 0);
                r_mm  = ($urandom_range(0, 3) != 0);
                r_wme = 1'($urandom_range(0, 1));
                r_a   = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(DEPTH, 65535))
                                                    : DW'($urandom_range(0, 63));
                r_fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, k + 2) : -1;
                op(r_rv, r_mm, r_wme, r_a, DW'($urandom), r_fl);
            end
        end

        chk = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
